// File: rtl/median_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window over a
// raster pixel stream. Emits one registered window per interior pixel position.
module median_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [9*DATA_W-1:0] out_win,
    output logic [COL_W-1:0]    out_col,
    output logic [ROW_W-1:0]    out_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_done
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             acc;
    logic             col_last;
    logic             row_last;
    logic             interior;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] a_rd;
    logic [DATA_W-1:0] b_rd;

    // win[r][c]: r=0 oldest row, c=0 oldest column; packing gives pixel 3*r+c
    logic [2:0][2:0][DATA_W-1:0] win;

    assign in_ready = rst_n && !restart && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;

    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign interior = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    assign a_rd    = lb0[col];
    assign b_rd    = lb1[col];
    assign out_win = win;

    // Line buffers carry no reset; stale rows are masked by the row >= 2 gate
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[col] <= b_rd;
            lb1[col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            out_col    <= '0;
            out_row    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (restart) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2]  <= a_rd;
            win[1][2]  <= b_rd;
            win[2][2]  <= in_data;
            out_valid  <= interior;
            out_col    <= col - COL_W'(1);
            out_row    <= row - ROW_W'(1);
            frame_done <= col_last && row_last;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboard bench for median_window_3x3 on a 4x4 image: directed frames, stall,
// bubbles, back-to-back frames, restart and mid-frame reset.
module tb_median_window_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          restart;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [9*DW-1:0] out_win;
    logic [1:0]    out_col;
    logic [1:0]    out_row;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;

    median_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_win(out_win), .out_col(out_col), .out_row(out_row),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*DW-1:0] win;
        logic [1:0]      col;
        logic [1:0]      row;
        logic            fd;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    // Hand-derived windows: pixel k=3r+c, k0 in the low byte
    logic [9*DW-1:0] win_first;
    logic [9*DW-1:0] win_last;
    logic [9*DW-1:0] win_f2_first;

    task automatic chk(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected windows of one frame whose pixel (r,c) value is base + 4r + c
    task automatic push_frame(input int base);
        exp_t e;
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                e.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[DW*(3*i+j) +: DW] = DW'(base + (r - 1 + i) * W + (c - 1 + j));
                e.col = 2'(c);
                e.row = 2'(r);
                e.fd  = (r == H - 2) && (c == W - 2);
                q.push_back(e);
            end
        end
    endtask

    // Present one pixel and hold it until accepted; returns cycles taken
    task automatic send(input logic [DW-1:0] d, output int cyc);
        bit ok;
        cyc = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 50);
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: pixel %0d not accepted in %0d cycles", d, cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int max_gap);
        int cyc;
        for (int p = first; p <= last; p++) begin
            send(DW'(p), cyc);
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_window: got %0h col %0d row %0d", out_win, out_col, out_row);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_win", out_win, e.win);
                chk("sb_col", 72'(out_col), 72'(e.col));
                chk("sb_row", 72'(out_row), 72'(e.row));
                chk("sb_frame_done", 72'(frame_done), 72'(e.fd));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        win_first    = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        win_last     = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        win_f2_first = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 72'(in_ready), 72'(0));
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_frame_done", 72'(frame_done), 72'(0));
        chk("rst_out_win", out_win, 72'(0));
        chk("rst_out_colrow", 72'({out_col, out_row}), 72'(0));
        rst_n = 1'b1;

        // Plain frame
        push_frame(0);
        send_range(0, 10, 0);
        chk("first_valid", 72'(out_valid), 72'(1));
        chk("first_win", out_win, win_first);
        chk("first_colrow", 72'({out_col, out_row}), 72'({2'd1, 2'd1}));
        send_range(11, 15, 0);
        chk("last_win", out_win, win_last);
        chk("last_frame_done", 72'(frame_done), 72'(1));
        chk("last_colrow", 72'({out_col, out_row}), 72'({2'd2, 2'd2}));

        // Backpressure with the first window pending
        push_frame(0);
        send_range(0, 10, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 72'(in_ready), 72'(0));
            chk("stall_out_valid", 72'(out_valid), 72'(1));
            chk("stall_win", out_win, win_first);
            chk("stall_colrow", 72'({out_col, out_row}), 72'({2'd1, 2'd1}));
            chk("stall_frame_done", 72'(frame_done), 72'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd11, cyc);
        chk("release_accept_cycles", 72'(cyc), 72'(1));
        send_range(12, 15, 0);

        // Random input bubbles
        push_frame(0);
        send_range(0, 15, 3);

        // Back-to-back frames
        push_frame(0);
        push_frame(100);
        send_range(0, 15, 0);
        send_range(100, 107, 0);
        chk("f2_no_early_windows", 72'(q.size()), 72'(4));
        send_range(108, 110, 0);
        chk("f2_first_win", out_win, win_f2_first);
        send_range(111, 115, 0);

        // Restart mid-frame
        send_range(0, 6, 0);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd7;
        @(negedge clk);
        chk("restart_in_ready", 72'(in_ready), 72'(0));
        @(posedge clk);
        #1;
        chk("restart_out_valid", 72'(out_valid), 72'(0));
        restart  = 1'b0;
        in_valid = 1'b0;
        push_frame(0);
        send_range(0, 15, 0);

        // Reset mid-frame
        send_range(0, 9, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 72'(in_ready), 72'(0));
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 72'(out_valid), 72'(0));
        chk("midrst_frame_done", 72'(frame_done), 72'(0));
        chk("midrst_out_win", out_win, 72'(0));
        chk("midrst_colrow", 72'({out_col, out_row}), 72'(0));
        rst_n = 1'b1;
        push_frame(0);
        send_range(0, 15, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 72'(q.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
